alu_mem_stage: RTL and testbench
================================

Name: alu_mem_stage

Overview:
Combined execute/memory stage of the single-cycle RV64 datapath. It holds three parts:
- ALU-control decoder: maps ALUOp and {instr[30], funct3} to a 4-bit ALU operation.
- 64-bit ALU with zero and signed-overflow flags.
- Doubleword-wide data memory addressed by the ALU result.
It also contains the write-back select mux, and sits between the register file/immediate mux and register write-back.

Parameters:
- DMEM_DWORDS, 128, number of 64-bit words in data memory (power of two).
- ADDR_LSB, 3, byte-offset bits ignored when indexing memory.

Ports:
- clk  input  1  stage clock; memory writes on rising edge.
- reset  input  1  asynchronous, active-high; clears data memory.
- alu_op  input  2  ALUOp from control unit.
- funct  input  4  {instr[30], instr[14:12]}.
- operand_a  input  64  rs1 value.
- operand_b  input  64  rs2 or immediate, already muxed.
- store_data  input  64  rs2 value written on store.
- mem_read  input  1  enables memory read data.
- mem_write  input  1  enables memory write at next clk edge.
- mem_to_reg  input  1  write-back select (1 = memory).
- alu_ctrl  output  4  decoded ALU operation.
- alu_result  output  64  ALU result; also the memory byte address.
- zero  output  1  alu_result == 0.
- overflow  output  1  signed overflow flag.
- mem_read_data  output  64  memory read data.
- wb_data  output  64  register write-back value.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high. Everything except the memory array is combinational, with zero latency.
- ALU-control decode:
  - ALUOp 00 -> ADD (0010).
  - ALUOp 01 -> SUB (0110).
  - ALUOp 10 (R-type): 0000 ADD, 1000 SUB, 0111 AND (0000), 0110 OR (0001), 0100 XOR (0011), 0001 SLL (0100), 0101 SRL (0101), 1101 SRA (0111), 0010 SLT (1000), 0011 SLTU (1001).
  - ALUOp 11 (I-type): decode funct3 only, same mapping. funct[3] is ignored except on funct3 = 101, where 1 selects SRA. funct3 = 000 is always ADD.
  - Any undefined combination -> 1111.
- ALU operations:
  - AND, OR, XOR: bitwise.
  - ADD, SUB: 64-bit two's complement, wrap on overflow.
  - Shifts: amount is operand_b[5:0]. SRA sign-fills.
  - SLT: signed compare, result is 1 or 0.
  - SLTU: unsigned compare, result is 1 or 0.
  - 1111: result 0.
- zero = (alu_result == 0), for every operation including 1111.
- overflow:
  - ADD: 1 when a and b have the same sign and the result sign differs.
  - SUB: 1 when a and b have different signs and the result sign differs from a.
  - 0 for all other operations.
- Memory indexing: index = alu_result[ADDR_LSB +: log2(DMEM_DWORDS)]. Low 3 bits and upper bits are ignored, so out-of-range addresses alias modulo memory size and misaligned addresses round down.
- Memory read: combinational. mem_read_data = mem[index] when mem_read = 1, otherwise 0.
- Memory write: on rising clk with mem_write = 1 and reset low, mem[index] <= store_data.
- Read and write in the same cycle to the same index: before the edge, read returns the old data; after the edge, the new data.
- mem_read and mem_write both asserted: both act.
- Reset: asserting reset clears every memory word to 0 immediately, with no clock needed. A write at a clock edge while reset is high is discarded. After reset, mem_read_data reads 0 for every address.
- wb_data = mem_to_reg ? mem_read_data : alu_result.

Optional Feature:
ALU_EXT_OPS_EN.
- Defined: XOR, SLL, SRL, SRA, SLT and SLTU are decoded and executed as above.
- Undefined: only ADD, SUB, AND and OR decode. All other funct values under ALUOp 10/11 produce alu_ctrl = 1111 and alu_result = 0.

Test Plan:
- ALUOp 10, funct 0000, a = 0x7FFFFFFFFFFFFFFF, b = 1 -> alu_ctrl 0010, result 0x8000000000000000, overflow 1, zero 0.
- ALUOp 01, a = 5, b = 5 -> alu_ctrl 0110, result 0, zero 1, overflow 0. Then funct 0111 with ALUOp 10, a = 0xF0, b = 0x3C -> alu_ctrl 0000, result 0x30.
- ALUOp 00, a = 0x10, b = 8 (address 0x18), store_data 0xDEADBEEF, mem_write 1, one clk -> then mem_read 1, mem_to_reg 1 -> mem_read_data and wb_data 0xDEADBEEF. mem_read 0 -> mem_read_data 0, wb_data 0x18.
- Write 0x1234 at address 0x18, then read address 0x1F and address 0x18 + 8*DMEM_DWORDS -> both return 0x1234 (rounding and aliasing).
- Write nonzero data, assert reset mid-cycle with no clock edge -> mem_read_data 0 immediately. A mem_write edge during reset leaves the location 0.
- With ALU_EXT_OPS_EN: funct 1101, ALUOp 10, a = 0x8000000000000000, b = 4 -> result 0xF800000000000000. funct 0010, a = -1, b = 1 -> result 1. Without the macro -> alu_ctrl 1111, result 0, zero 1.

Source files
------------

// File: rtl/alu_mem_stage.sv
// alu_mem_stage
//   Execute/memory stage of a single-cycle RV64 datapath. It holds:
//     - an ALU-control decoder (ALUOp + {instr[30], funct3} -> 4-bit op)
//     - a 64-bit ALU with zero and signed-overflow flags
//     - a doubleword data memory addressed by the ALU result
//     - the write-back select mux
//   Only the memory array is clocked; everything else is combinational.
//
// Optional feature macro: ALU_EXT_OPS_EN
//   Defined   : XOR, SLL, SRL, SRA, SLT and SLTU are decoded and executed.
//   Undefined : only ADD, SUB, AND and OR decode; every other funct under
//               ALUOp 10/11 yields alu_ctrl = 1111 and alu_result = 0.
//
// Parameters
//   DMEM_DWORDS : number of 64-bit words in data memory (power of two)
//   ADDR_LSB    : byte-offset bits ignored when indexing memory
//
// Ports
//   clk           in   stage clock, memory writes on rising edge
//   reset         in   asynchronous active-high, clears data memory
//   alu_op[1:0]   in   ALUOp from control unit
//   funct[3:0]    in   {instr[30], instr[14:12]}
//   operand_a     in   rs1 value
//   operand_b     in   rs2 or immediate
//   store_data    in   rs2 value written on store
//   mem_read      in   enables memory read data
//   mem_write     in   enables memory write at next clk edge
//   mem_to_reg    in   write-back select (1 = memory)
//   alu_ctrl      out  decoded ALU operation
//   alu_result    out  ALU result, also the memory byte address
//   zero          out  alu_result == 0
//   overflow      out  signed overflow flag (ADD/SUB only)
//   mem_read_data out  memory read data (0 when mem_read is low)
//   wb_data       out  register write-back value

module alu_mem_stage #(
   parameter int DMEM_DWORDS = 128,
   parameter int ADDR_LSB    = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  alu_op,
   input  logic [3:0]  funct,
   input  logic [63:0] operand_a,
   input  logic [63:0] operand_b,
   input  logic [63:0] store_data,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        mem_to_reg,
   output logic [3:0]  alu_ctrl,
   output logic [63:0] alu_result,
   output logic        zero,
   output logic        overflow,
   output logic [63:0] mem_read_data,
   output logic [63:0] wb_data
);

   localparam int IDX_W = $clog2(DMEM_DWORDS);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;
   localparam logic [3:0] OP_NONE = 4'b1111;

   // ALU-control decode
   always_comb begin
      alu_ctrl = OP_NONE;
      case (alu_op)
         2'b00: alu_ctrl = OP_ADD;
         2'b01: alu_ctrl = OP_SUB;
         2'b10: begin
            case (funct)
               4'b0000: alu_ctrl = OP_ADD;
               4'b1000: alu_ctrl = OP_SUB;
               4'b0111: alu_ctrl = OP_AND;
               4'b0110: alu_ctrl = OP_OR;
`ifdef ALU_EXT_OPS_EN
               4'b0100: alu_ctrl = OP_XOR;
               4'b0001: alu_ctrl = OP_SLL;
               4'b0101: alu_ctrl = OP_SRL;
               4'b1101: alu_ctrl = OP_SRA;
               4'b0010: alu_ctrl = OP_SLT;
               4'b0011: alu_ctrl = OP_SLTU;
`endif
               default: alu_ctrl = OP_NONE;
            endcase
         end
         2'b11: begin
            // I-type: instr[30] is part of the immediate except for the
            // shift-right encoding, where it picks arithmetic vs logical.
            case (funct[2:0])
               3'b000: alu_ctrl = OP_ADD;
               3'b111: alu_ctrl = OP_AND;
               3'b110: alu_ctrl = OP_OR;
`ifdef ALU_EXT_OPS_EN
               3'b100: alu_ctrl = OP_XOR;
               3'b001: alu_ctrl = OP_SLL;
               3'b101: alu_ctrl = funct[3] ? OP_SRA : OP_SRL;
               3'b010: alu_ctrl = OP_SLT;
               3'b011: alu_ctrl = OP_SLTU;
`endif
               default: alu_ctrl = OP_NONE;
            endcase
         end
         default: alu_ctrl = OP_NONE;
      endcase
   end

   // ALU
   logic [63:0] sum;
   logic [63:0] diff;
   logic [5:0]  shamt;

   assign sum   = operand_a + operand_b;
   assign diff  = operand_a - operand_b;
   assign shamt = operand_b[5:0];

   always_comb begin
      alu_result = 64'd0;
      case (alu_ctrl)
         OP_ADD:  alu_result = sum;
         OP_SUB:  alu_result = diff;
         OP_AND:  alu_result = operand_a & operand_b;
         OP_OR:   alu_result = operand_a | operand_b;
`ifdef ALU_EXT_OPS_EN
         OP_XOR:  alu_result = operand_a ^ operand_b;
         OP_SLL:  alu_result = operand_a << shamt;
         OP_SRL:  alu_result = operand_a >> shamt;
         OP_SRA:  alu_result = $unsigned($signed(operand_a) >>> shamt);
         OP_SLT:  alu_result = {63'd0, $signed(operand_a) < $signed(operand_b)};
         OP_SLTU: alu_result = {63'd0, operand_a < operand_b};
`endif
         default: alu_result = 64'd0;
      endcase
   end

   assign zero = (alu_result == 64'd0);

   always_comb begin
      overflow = 1'b0;
      case (alu_ctrl)
         OP_ADD:  overflow = (operand_a[63] == operand_b[63]) && (sum[63]  != operand_a[63]);
         OP_SUB:  overflow = (operand_a[63] != operand_b[63]) && (diff[63] != operand_a[63]);
         default: overflow = 1'b0;
      endcase
   end

   // Data memory: upper address bits alias, low byte-offset bits round down.
   logic [63:0]      mem [DMEM_DWORDS];
   logic [IDX_W-1:0] mem_idx;

   assign mem_idx = alu_result[ADDR_LSB +: IDX_W];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DMEM_DWORDS; i++) begin
            mem[i] <= 64'd0;
         end
      end else if (mem_write) begin
         mem[mem_idx] <= store_data;
      end
   end

   assign mem_read_data = mem_read ? mem[mem_idx] : 64'd0;
   assign wb_data       = mem_to_reg ? mem_read_data : alu_result;

endmodule

// File: tb/tb_alu_mem_stage.sv
module tb_alu_mem_stage;

   logic        clk;
   logic        reset;
   logic [1:0]  alu_op;
   logic [3:0]  funct;
   logic [63:0] operand_a;
   logic [63:0] operand_b;
   logic [63:0] store_data;
   logic        mem_read;
   logic        mem_write;
   logic        mem_to_reg;
   logic [3:0]  alu_ctrl;
   logic [63:0] alu_result;
   logic        zero;
   logic        overflow;
   logic [63:0] mem_read_data;
   logic [63:0] wb_data;

   int n_cmp;
   int n_err;

   alu_mem_stage #(.DMEM_DWORDS(128), .ADDR_LSB(3)) dut (
      .clk           (clk),
      .reset         (reset),
      .alu_op        (alu_op),
      .funct         (funct),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .store_data    (store_data),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_to_reg    (mem_to_reg),
      .alu_ctrl      (alu_ctrl),
      .alu_result    (alu_result),
      .zero          (zero),
      .overflow      (overflow),
      .mem_read_data (mem_read_data),
      .wb_data       (wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      reset = 1'b1; alu_op = 2'b00; funct = 4'b0000;
      operand_a = 64'h18; operand_b = 64'h0; store_data = 64'h0;
      mem_read = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1;
      #2;
      n_cmp++; if (mem_read_data !== 64'h0) begin n_err++; $display("FAIL reset_rd got %h exp %h", mem_read_data, 64'h0); end
      n_cmp++; if (wb_data !== 64'h0) begin n_err++; $display("FAIL reset_wb got %h exp %h", wb_data, 64'h0); end
      n_cmp++; if (alu_ctrl !== 4'b0010) begin n_err++; $display("FAIL reset_ctrl got %b exp %b", alu_ctrl, 4'b0010); end
      n_cmp++; if (alu_result !== 64'h18) begin n_err++; $display("FAIL reset_res got %h exp %h", alu_result, 64'h18); end
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   task automatic test_alu();
      mem_read = 1'b0; mem_to_reg = 1'b0;
      // ADD with signed overflow
      alu_op = 2'b10; funct = 4'b0000;
      operand_a = 64'h7FFF_FFFF_FFFF_FFFF; operand_b = 64'h1;
      #1;
      n_cmp++; if (alu_ctrl !== 4'b0010) begin n_err++; $display("FAIL add_ctrl got %b exp %b", alu_ctrl, 4'b0010); end
      n_cmp++; if (alu_result !== 64'h8000_0000_0000_0000) begin n_err++; $display("FAIL add_res got %h exp %h", alu_result, 64'h8000_0000_0000_0000); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL add_ovf got %b exp 1", overflow); end
      n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL add_zero got %b exp 0", zero); end
      n_cmp++; if (wb_data !== 64'h8000_0000_0000_0000) begin n_err++; $display("FAIL add_wb got %h exp %h", wb_data, 64'h8000_0000_0000_0000); end
      // SUB equal operands
      alu_op = 2'b01; operand_a = 64'd5; operand_b = 64'd5;
      #1;
      n_cmp++; if (alu_ctrl !== 4'b0110) begin n_err++; $display("FAIL sub_ctrl got %b exp %b", alu_ctrl, 4'b0110); end
      n_cmp++; if (alu_result !== 64'h0) begin n_err++; $display("FAIL sub_res got %h exp 0", alu_result); end
      n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL sub_zero got %b exp 1", zero); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL sub_ovf got %b exp 0", overflow); end
      // SUB with signed overflow
      operand_a = 64'h8000_0000_0000_0000; operand_b = 64'h1;
      #1;
      n_cmp++; if (alu_result !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL sub2_res got %h exp %h", alu_result, 64'h7FFF_FFFF_FFFF_FFFF); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL sub2_ovf got %b exp 1", overflow); end
      // R-type SUB through funct
      alu_op = 2'b10; funct = 4'b1000; operand_a = 64'd3; operand_b = 64'd10;
      #1;
      n_cmp++; if (alu_result !== 64'hFFFF_FFFF_FFFF_FFF9) begin n_err++; $display("FAIL rsub_res got %h exp %h", alu_result, 64'hFFFF_FFFF_FFFF_FFF9); end
      // AND
      funct = 4'b0111; operand_a = 64'hF0; operand_b = 64'h3C;
      #1;
      n_cmp++; if (alu_ctrl !== 4'b0000) begin n_err++; $display("FAIL and_ctrl got %b exp %b", alu_ctrl, 4'b0000); end
      n_cmp++; if (alu_result !== 64'h30) begin n_err++; $display("FAIL and_res got %h exp %h", alu_result, 64'h30); end
      // OR
      funct = 4'b0110; operand_a = 64'hF0; operand_b = 64'h0F;
      #1;
      n_cmp++; if (alu_ctrl !== 4'b0001) begin n_err++; $display("FAIL or_ctrl got %b exp %b", alu_ctrl, 4'b0001); end
      n_cmp++; if (alu_result !== 64'hFF) begin n_err++; $display("FAIL or_res got %h exp %h", alu_result, 64'hFF); end
      // I-type ADD ignores funct[3]
      alu_op = 2'b11; funct = 4'b1000; operand_a = 64'd7; operand_b = 64'd9;
      #1;
      n_cmp++; if (alu_ctrl !== 4'b0010) begin n_err++; $display("FAIL iadd_ctrl got %b exp %b", alu_ctrl, 4'b0010); end
      n_cmp++; if (alu_result !== 64'd16) begin n_err++; $display("FAIL iadd_res got %h exp %h", alu_result, 64'd16); end
      // Undefined R-type funct
      alu_op = 2'b10; funct = 4'b1111; operand_a = 64'd7; operand_b = 64'd9;
      #1;
      n_cmp++; if (alu_ctrl !== 4'b1111) begin n_err++; $display("FAIL undef_ctrl got %b exp %b", alu_ctrl, 4'b1111); end
      n_cmp++; if (alu_result !== 64'h0) begin n_err++; $display("FAIL undef_res got %h exp 0", alu_result); end
      n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL undef_zero got %b exp 1", zero); end
   endtask

   task automatic test_ext_ops();
      logic [3:0]  exp_ctrl;
      logic [63:0] exp_res;
      mem_read = 1'b0; mem_to_reg = 1'b0;
      // SRA
      alu_op = 2'b10; funct = 4'b1101;
      operand_a = 64'h8000_0000_0000_0000; operand_b = 64'd4;
`ifdef ALU_EXT_OPS_EN
      exp_ctrl = 4'b0111; exp_res = 64'hF800_0000_0000_0000;
`else
      exp_ctrl = 4'b1111; exp_res = 64'h0;
`endif
      #1;
      n_cmp++; if (alu_ctrl !== exp_ctrl) begin n_err++; $display("FAIL sra_ctrl got %b exp %b", alu_ctrl, exp_ctrl); end
      n_cmp++; if (alu_result !== exp_res) begin n_err++; $display("FAIL sra_res got %h exp %h", alu_result, exp_res); end
      n_cmp++; if (zero !== (exp_res == 64'h0)) begin n_err++; $display("FAIL sra_zero got %b exp %b", zero, exp_res == 64'h0); end
      // SLT signed
      funct = 4'b0010; operand_a = 64'hFFFF_FFFF_FFFF_FFFF; operand_b = 64'd1;
`ifdef ALU_EXT_OPS_EN
      exp_ctrl = 4'b1000; exp_res = 64'd1;
`else
      exp_ctrl = 4'b1111; exp_res = 64'h0;
`endif
      #1;
      n_cmp++; if (alu_ctrl !== exp_ctrl) begin n_err++; $display("FAIL slt_ctrl got %b exp %b", alu_ctrl, exp_ctrl); end
      n_cmp++; if (alu_result !== exp_res) begin n_err++; $display("FAIL slt_res got %h exp %h", alu_result, exp_res); end
      // SLTU on the same operands: -1 is the largest unsigned value
      funct = 4'b0011;
`ifdef ALU_EXT_OPS_EN
      exp_ctrl = 4'b1001;
`else
      exp_ctrl = 4'b1111;
`endif
      #1;
      n_cmp++; if (alu_ctrl !== exp_ctrl) begin n_err++; $display("FAIL sltu_ctrl got %b exp %b", alu_ctrl, exp_ctrl); end
      n_cmp++; if (alu_result !== 64'h0) begin n_err++; $display("FAIL sltu_res got %h exp 0", alu_result); end
      // I-type SLL, shift amount taken from operand_b[5:0] only
      alu_op = 2'b11; funct = 4'b0001; operand_a = 64'd1; operand_b = 64'h43;
`ifdef ALU_EXT_OPS_EN
      exp_ctrl = 4'b0100; exp_res = 64'd8;
`else
      exp_ctrl = 4'b1111; exp_res = 64'h0;
`endif
      #1;
      n_cmp++; if (alu_ctrl !== exp_ctrl) begin n_err++; $display("FAIL slli_ctrl got %b exp %b", alu_ctrl, exp_ctrl); end
      n_cmp++; if (alu_result !== exp_res) begin n_err++; $display("FAIL slli_res got %h exp %h", alu_result, exp_res); end
      // I-type 101 with funct[3] = 0 is SRL (zero fill)
      funct = 4'b0101; operand_a = 64'h8000_0000_0000_0000; operand_b = 64'd4;
`ifdef ALU_EXT_OPS_EN
      exp_ctrl = 4'b0101; exp_res = 64'h0800_0000_0000_0000;
`else
      exp_ctrl = 4'b1111; exp_res = 64'h0;
`endif
      #1;
      n_cmp++; if (alu_ctrl !== exp_ctrl) begin n_err++; $display("FAIL srli_ctrl got %b exp %b", alu_ctrl, exp_ctrl); end
      n_cmp++; if (alu_result !== exp_res) begin n_err++; $display("FAIL srli_res got %h exp %h", alu_result, exp_res); end
   endtask

   task automatic test_mem_rw();
      @(negedge clk);
      alu_op = 2'b00; funct = 4'b0000; operand_a = 64'h10; operand_b = 64'h8;
      store_data = 64'hDEAD_BEEF; mem_write = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1;
      #1;
      n_cmp++; if (mem_read_data !== 64'h0) begin n_err++; $display("FAIL rw_before got %h exp 0", mem_read_data); end
      @(posedge clk); #1;
      mem_write = 1'b0;
      n_cmp++; if (mem_read_data !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL rw_rd got %h exp %h", mem_read_data, 64'hDEAD_BEEF); end
      n_cmp++; if (wb_data !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL rw_wb got %h exp %h", wb_data, 64'hDEAD_BEEF); end
      mem_read = 1'b0; mem_to_reg = 1'b0;
      #1;
      n_cmp++; if (mem_read_data !== 64'h0) begin n_err++; $display("FAIL rw_rdoff got %h exp 0", mem_read_data); end
      n_cmp++; if (wb_data !== 64'h18) begin n_err++; $display("FAIL rw_wbalu got %h exp %h", wb_data, 64'h18); end
      // Neighbouring word untouched
      mem_read = 1'b1; operand_a = 64'h20; operand_b = 64'h0;
      #1;
      n_cmp++; if (mem_read_data !== 64'h0) begin n_err++; $display("FAIL rw_neigh got %h exp 0", mem_read_data); end
   endtask

   task automatic test_alias();
      @(negedge clk);
      alu_op = 2'b00; operand_a = 64'h18; operand_b = 64'h0;
      store_data = 64'h1234; mem_write = 1'b1; mem_read = 1'b0; mem_to_reg = 1'b0;
      @(posedge clk); #1;
      mem_write = 1'b0; mem_read = 1'b1;
      operand_a = 64'h1F;
      #1;
      n_cmp++; if (mem_read_data !== 64'h1234) begin n_err++; $display("FAIL align got %h exp %h", mem_read_data, 64'h1234); end
      operand_a = 64'h18 + 64'd8 * 64'd128;
      #1;
      n_cmp++; if (mem_read_data !== 64'h1234) begin n_err++; $display("FAIL alias got %h exp %h", mem_read_data, 64'h1234); end
   endtask

   task automatic test_reset_clear();
      @(negedge clk);
      alu_op = 2'b00; operand_a = 64'h40; operand_b = 64'h0;
      store_data = 64'hABCD; mem_write = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1;
      @(posedge clk); #1;
      mem_write = 1'b0;
      n_cmp++; if (mem_read_data !== 64'hABCD) begin n_err++; $display("FAIL pre_rst got %h exp %h", mem_read_data, 64'hABCD); end
      #1;
      reset = 1'b1;
      #1;
      n_cmp++; if (mem_read_data !== 64'h0) begin n_err++; $display("FAIL async_rst got %h exp 0", mem_read_data); end
      operand_a = 64'h18;
      #1;
      n_cmp++; if (mem_read_data !== 64'h0) begin n_err++; $display("FAIL rst_other got %h exp 0", mem_read_data); end
      operand_a = 64'h40; store_data = 64'h5555; mem_write = 1'b1;
      @(posedge clk); #1;
      mem_write = 1'b0;
      reset = 1'b0;
      #1;
      n_cmp++; if (mem_read_data !== 64'h0) begin n_err++; $display("FAIL wr_in_rst got %h exp 0", mem_read_data); end
      n_cmp++; if (wb_data !== 64'h0) begin n_err++; $display("FAIL wr_in_rst_wb got %h exp 0", wb_data); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_alu();
      test_ext_ops();
      test_mem_rw();
      test_alias();
      test_reset_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
